router_output_arbiter: RTL and testbench
========================================

// Module: router_output_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for one router output port. Shares a single-entry
//  output buffer among N_IN single-entry input buffers. Picks one full input whose
//  packet targets this port, then pulses that input's read enable and the output
//  buffer's write enable in the same cycle, steering the input's data across.
//  One instance sits per output port (N/E/S/W/local) in the router datapath.
// PARAMETERS
//  N_IN      4   number of requesting input buffers (2..8)
//  DATA_SIZE 64  flit width in bits
//  CNT_W     16  width of the completed-transfer counter
//  (localparam IDX_W = $clog2(N_IN))
// PORTS
//  clk        in   1              clock, all state updates on posedge
//  reset      in   1              synchronous, active-high
//  req        in   N_IN           req[i]=1: input buffer i full and targets this port
//  data_in    in   N_IN*DATA_SIZE input flits; flit i = data_in[i*DATA_SIZE +: DATA_SIZE]
//  out_full   in   1              output buffer full flag
//  re         out  N_IN           one-hot read enable to input buffers
//  we         out  1              write enable to output buffer
//  data_out   out  DATA_SIZE      flit steered to output buffer
//  gnt_id     out  IDX_W          registered index of current/last grant
//  busy       out  1              1 while FSM is in XFER
//  xfer_count out  CNT_W          number of completed transfers, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, gnt_id=0, xfer_count=0; re=0, we=0, busy=0.
//   data_out follows data_in[gnt_id], i.e. flit 0 after reset.
//  Reset mid-XFER: re/we are gated to 0 in that cycle, so no transfer happens.
//  FSM, two states:
//   IDLE: if (|req && !out_full) -> latch gnt_id = RR winner, go XFER.
//    Otherwise stay in IDLE. re=0, we=0.
//   XFER: if (req[gnt_id] && !out_full): re[gnt_id]=1, we=1 for exactly this cycle,
//    rr_ptr <= (gnt_id==N_IN-1) ? 0 : gnt_id+1, xfer_count++, go IDLE.
//    Otherwise (abort): re=0, we=0, rr_ptr unchanged, count unchanged, go IDLE.
//  RR winner: first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... wrapping N_IN-1->0.
//  re/we/data_out are combinational from state, gnt_id, req and out_full. There is
//   no combinational path from req to re other than via the req[gnt_id] gate.
//  data_out = data_in[gnt_id*DATA_SIZE +: DATA_SIZE] at all times.
//  Latency: request sampled in IDLE cycle T -> re/we asserted in T+1.
//   Peak throughput is 1 flit per 2 cycles.
//  The buffer status updates at the T+1 edge, so IDLE in T+2 sees the new req/out_full.
//  re is one-hot or zero. re!=0 implies we=1, and we=1 implies re!=0.
//  A requester that drops req before XFER loses its turn (abort).
//   Its priority is retained because rr_ptr is unchanged.
//  xfer_count wraps from 2^CNT_W-1 to 0 with no flag.
// TESTING
//  1 reset, req=0010, out_full=0 -> T+1: re=0010, we=1, data_out=flit1;
//    then rr_ptr=2, xfer_count=1.
//  2 req=1111 held, out_full=0 each IDLE cycle -> grants 0,1,2,3,0 in order,
//    we pulses on every 2nd cycle.
//  3 req=0100, out_full=1 for 10 cycles -> re=0, we=0, busy=0 throughout;
//    out_full=0 -> grant 2 next cycle.
//  4 req=1000 granted; out_full forced 1 during XFER -> no re/we, rr_ptr and count
//    unchanged; regrant after release.
//  5 reset asserted during XFER with req=0001 -> re=0, we=0 that cycle;
//    next cycle state=IDLE, count=0, gnt_id=0.
//  6 CNT_W=4, 16 transfers -> xfer_count returns to 0;
//    rr_ptr wraps 3->0 after a grant to input 3.

Source files
------------

// File: rtl/router_output_arbiter.sv
// Round-robin output-port arbiter: moves one flit from a requesting
// input buffer into the shared single-entry output buffer.
module router_output_arbiter #(
    parameter  int N_IN      = 4,
    parameter  int DATA_SIZE = 64,
    parameter  int CNT_W     = 16,
    localparam int IDX_W     = $clog2(N_IN)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_IN-1:0]           req,
    input  logic [N_IN*DATA_SIZE-1:0] data_in,
    input  logic                      out_full,
    output logic [N_IN-1:0]           re,
    output logic                      we,
    output logic [DATA_SIZE-1:0]      data_out,
    output logic [IDX_W-1:0]          gnt_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          xfer_count
);

    typedef enum logic {
        S_IDLE,
        S_XFER
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_gnt_id;
    logic [CNT_W-1:0] r_cnt;

    logic [IDX_W-1:0] w_win;
    logic             w_found;
    logic             w_req_gnt;
    logic             w_do_xfer;
    logic             w_latch;
    logic [IDX_W-1:0] w_ptr_nxt;

    // Round-robin winner: first requester at or after r_rr_ptr, wrapping.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            for (int p = 0; p < N_IN; p++) begin
                if (!w_found && r_rr_ptr == IDX_W'(p)
                    && req[(p + k) % N_IN]) begin
                    w_found = 1'b1;
                    w_win   = IDX_W'((p + k) % N_IN);
                end
            end
        end
    end

    // Request bit of the latched grantee; the only req-to-re path.
    always_comb begin
        w_req_gnt = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (r_gnt_id == IDX_W'(i)) begin
                w_req_gnt = req[i];
            end
        end
    end

    // Steer the grantee's flit to the output buffer.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (r_gnt_id == IDX_W'(i)) begin
                data_out = data_in[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Next state and transfer strobes.
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_do_xfer = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|req && !out_full) begin
                    w_latch = 1'b1;
                    w_next  = S_XFER;
                end
            end
            S_XFER: begin
                w_next = S_IDLE;
                // Reset in this cycle must suppress the handoff.
                if (w_req_gnt && !out_full && !reset) begin
                    w_do_xfer = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pointer moves to the slot just after the served input.
    always_comb begin
        if (r_gnt_id == IDX_W'(N_IN - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = r_gnt_id + 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_gnt_id <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_gnt_id <= w_win;
            end
            if (w_do_xfer) begin
                r_rr_ptr <= w_ptr_nxt;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    // Registered and strobe outputs.
    always_comb begin
        re = '0;
        if (w_do_xfer) begin
            re[r_gnt_id] = 1'b1;
        end
    end

    assign we         = w_do_xfer;
    assign busy       = (r_state == S_XFER);
    assign gnt_id     = r_gnt_id;
    assign xfer_count = r_cnt;

    a_re_onehot : assert property (@(posedge clk) $onehot0(re));
    a_re_we     : assert property (@(posedge clk) (re != '0) == we);

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: scoreboard of expected transfers
// plus per-scenario inline checks.
module tb_router_output_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data_in;
    logic            out_full;
    logic [N-1:0]    re;
    logic            we;
    logic [DW-1:0]   data_out;
    logic [1:0]      gnt_id;
    logic            busy;
    logic [CW-1:0]   xfer_count;

    router_output_arbiter #(
        .N_IN(N),
        .DATA_SIZE(DW),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .data_in(data_in),
        .out_full(out_full),
        .re(re),
        .we(we),
        .data_out(data_out),
        .gnt_id(gnt_id),
        .busy(busy),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [DW-1:0] flit;
    } exp_t;

    exp_t          sb[$];
    exp_t          m_e;
    logic [N-1:0]  m_re;
    logic [DW-1:0] flit[N];
    int            m_rr;
    int            m_cnt;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every write must match the oldest expected flit.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            n_cmp++;
            if (((re != '0) !== we) || ($countones(re) > 1)) begin
                n_err++;
                $display("FAIL re_we_pair re=%b we=%b", re, we);
            end
            if (we === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_we gnt=%0d re=%b required no write",
                             gnt_id, re);
                end else begin
                    m_e  = sb.pop_front();
                    m_re = '0;
                    m_re[m_e.idx] = 1'b1;
                    if (gnt_id !== 2'(m_e.idx) || re !== m_re
                        || data_out !== m_e.flit) begin
                        n_err++;
                        $display("FAIL sb_xfer gnt=%0d re=%b data=%h required gnt=%0d re=%b data=%h",
                                 gnt_id, re, data_out, m_e.idx, m_re, m_e.flit);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        reset    = 1'b1;
        req      = '0;
        out_full = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m_rr  = 0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req      = '0;
        out_full = 1'b0;
        tick();
        tick();
        mid();
        n_cmp++;
        if (re !== '0 || we !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_strobes re=%b we=%b busy=%b required 0/0/0",
                     re, we, busy);
        end
        n_cmp++;
        if (gnt_id !== 2'd0 || xfer_count !== '0) begin
            n_err++;
            $display("FAIL reset_regs gnt=%0d cnt=%0d required 0/0",
                     gnt_id, xfer_count);
        end
        n_cmp++;
        if (data_out !== flit[0]) begin
            n_err++;
            $display("FAIL reset_data data=%h required %h", data_out, flit[0]);
        end
        tick();
        reset = 1'b0;
        m_rr  = 0;
        m_cnt = 0;
        mid();
    endtask

    task automatic test_single();
        int w;
        tick();
        req = 4'b0010;
        w   = rr_pick(req, m_rr);
        sb.push_back('{w, flit[w]});
        tick();
        mid();
        n_cmp++;
        if (we !== 1'b1 || re !== 4'b0010 || data_out !== flit[1]) begin
            n_err++;
            $display("FAIL single_xfer we=%b re=%b data=%h required 1/0010/%h",
                     we, re, data_out, flit[1]);
        end
        tick();
        req   = '0;
        m_rr  = (w + 1) % N;
        m_cnt = (m_cnt + 1) % 16;
        mid();
        n_cmp++;
        if (xfer_count !== 4'd1 || busy !== 1'b0 || gnt_id !== 2'd1) begin
            n_err++;
            $display("FAIL single_after cnt=%0d busy=%b gnt=%0d required 1/0/1",
                     xfer_count, busy, gnt_id);
        end
        tick();
        req = 4'b0110;
        w   = rr_pick(req, m_rr);
        sb.push_back('{w, flit[w]});
        tick();
        mid();
        n_cmp++;
        if (gnt_id !== 2'd2 || we !== 1'b1) begin
            n_err++;
            $display("FAIL single_ptr gnt=%0d we=%b required 2/1", gnt_id, we);
        end
        tick();
        req   = '0;
        m_rr  = (w + 1) % N;
        m_cnt = (m_cnt + 1) % 16;
        mid();
    endtask

    task automatic test_round_robin();
        int w;
        apply_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = rr_pick(req, m_rr);
            sb.push_back('{w, flit[w]});
            tick();
            mid();
            n_cmp++;
            if (we !== 1'b1 || gnt_id !== 2'(w)) begin
                n_err++;
                $display("FAIL rr_grant k=%0d we=%b gnt=%0d required 1/%0d",
                         k, we, gnt_id, w);
            end
            tick();
            if (k == 4) req = '0;
            m_rr  = (w + 1) % N;
            m_cnt = (m_cnt + 1) % 16;
            mid();
            n_cmp++;
            if (we !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rr_gap k=%0d we=%b busy=%b required 0/0",
                         k, we, busy);
            end
        end
        n_cmp++;
        if (xfer_count !== 4'(m_cnt)) begin
            n_err++;
            $display("FAIL rr_count cnt=%0d required %0d", xfer_count, m_cnt);
        end
    endtask

    task automatic test_out_full();
        int w;
        tick();
        req      = 4'b0100;
        out_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mid();
            n_cmp++;
            if (re !== '0 || we !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL full_hold k=%0d re=%b we=%b busy=%b required 0/0/0",
                         k, re, we, busy);
            end
            tick();
        end
        out_full = 1'b0;
        w = rr_pick(req, m_rr);
        sb.push_back('{w, flit[w]});
        tick();
        mid();
        n_cmp++;
        if (busy !== 1'b1 || we !== 1'b1 || gnt_id !== 2'd2) begin
            n_err++;
            $display("FAIL full_release busy=%b we=%b gnt=%0d required 1/1/2",
                     busy, we, gnt_id);
        end
        tick();
        req   = '0;
        m_rr  = (w + 1) % N;
        m_cnt = (m_cnt + 1) % 16;
        mid();
        n_cmp++;
        if (xfer_count !== 4'(m_cnt)) begin
            n_err++;
            $display("FAIL full_count cnt=%0d required %0d", xfer_count, m_cnt);
        end
    endtask

    task automatic test_abort();
        int w;
        tick();
        req      = 4'b1000;
        out_full = 1'b0;
        tick();
        out_full = 1'b1;
        mid();
        n_cmp++;
        if (busy !== 1'b1 || we !== 1'b0 || re !== '0 || gnt_id !== 2'd3) begin
            n_err++;
            $display("FAIL abort_xfer busy=%b we=%b re=%b gnt=%0d required 1/0/0000/3",
                     busy, we, re, gnt_id);
        end
        tick();
        mid();
        n_cmp++;
        if (xfer_count !== 4'(m_cnt) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_after cnt=%0d busy=%b required %0d/0",
                     xfer_count, busy, m_cnt);
        end
        tick();
        req      = 4'b1001;
        out_full = 1'b0;
        w = rr_pick(req, m_rr);
        sb.push_back('{w, flit[w]});
        tick();
        mid();
        n_cmp++;
        if (we !== 1'b1 || gnt_id !== 2'd3) begin
            n_err++;
            $display("FAIL abort_regrant we=%b gnt=%0d required 1/3", we, gnt_id);
        end
        tick();
        req   = '0;
        m_rr  = (w + 1) % N;
        m_cnt = (m_cnt + 1) % 16;
        mid();
        n_cmp++;
        if (xfer_count !== 4'(m_cnt)) begin
            n_err++;
            $display("FAIL abort_count cnt=%0d required %0d", xfer_count, m_cnt);
        end
    endtask

    task automatic test_reset_mid_xfer();
        tick();
        req      = 4'b0001;
        out_full = 1'b0;
        tick();
        reset = 1'b1;
        mid();
        n_cmp++;
        if (re !== '0 || we !== 1'b0) begin
            n_err++;
            $display("FAIL rst_xfer re=%b we=%b required 0000/0", re, we);
        end
        tick();
        reset = 1'b0;
        req   = '0;
        m_rr  = 0;
        m_cnt = 0;
        mid();
        n_cmp++;
        if (busy !== 1'b0 || xfer_count !== '0 || gnt_id !== 2'd0) begin
            n_err++;
            $display("FAIL rst_after busy=%b cnt=%0d gnt=%0d required 0/0/0",
                     busy, xfer_count, gnt_id);
        end
    endtask

    task automatic test_wrap();
        int w;
        tick();
        req = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            w = rr_pick(req, m_rr);
            sb.push_back('{w, flit[w]});
            tick();
            mid();
            n_cmp++;
            if (gnt_id !== 2'(w) || we !== 1'b1) begin
                n_err++;
                $display("FAIL wrap_grant k=%0d gnt=%0d we=%b required %0d/1",
                         k, gnt_id, we, w);
            end
            tick();
            if (k == 15) req = '0;
            m_rr  = (w + 1) % N;
            m_cnt = (m_cnt + 1) % 16;
            mid();
            n_cmp++;
            if (xfer_count !== 4'(m_cnt)) begin
                n_err++;
                $display("FAIL wrap_count k=%0d cnt=%0d required %0d",
                         k, xfer_count, m_cnt);
            end
        end
        n_cmp++;
        if (xfer_count !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_zero cnt=%0d required 0", xfer_count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        out_full = 1'b0;
        m_rr     = 0;
        m_cnt    = 0;
        for (int i = 0; i < N; i++) begin
            flit[i] = 64'h0123_4567_89AB_CDEF
                      ^ (64'(i + 1) * 64'h1111_1111_1111_1111);
            data_in[i*DW +: DW] = flit[i];
        end
        test_reset();
        test_single();
        test_round_robin();
        test_out_full();
        test_abort();
        test_reset_mid_xfer();
        test_wrap();
        tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain pending=%0d required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
